codec_config_sequencer: RTL and testbench

Power-up and runtime configuration controller for the audio codec. It sequences a fixed table of 16-bit control words to the codec through the SPI master. Only after the full sequence completes does it enable the I2S audio datapath (deserializer → monitor controller → serializer). Once the codec is running it also accepts runtime headphone-volume requests, issuing them as single SPI writes.

---
 rtl/codec_config_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_codec_config_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_config_sequencer.sv
// Codec configuration sequencer: replays a fixed table of control words through the SPI master,
// then enables the audio datapath and forwards runtime headphone-volume writes.
module codec_config_sequencer #(
    parameter int unsigned POWER_UP_DELAY_CYCLES  = 1_000_000,
    parameter int unsigned INTER_WRITE_GAP_CYCLES = 16,
    parameter int unsigned SPI_TIMEOUT_CYCLES     = 65_536
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    output logic [15:0] o_spi_data,
    output logic        o_spi_valid,
    input  logic        i_spi_ready,
    input  logic        i_spi_done,
    input  logic        i_volume_valid,
    input  logic [6:0]  i_volume_value,
    output logic        o_volume_ready,
    output logic        o_datapath_enable,
    output logic        o_init_done,
    output logic        o_error
);

    localparam int unsigned MaxA   = (POWER_UP_DELAY_CYCLES > INTER_WRITE_GAP_CYCLES) ?
                                     POWER_UP_DELAY_CYCLES : INTER_WRITE_GAP_CYCLES;
    localparam int unsigned MaxCnt = (MaxA > SPI_TIMEOUT_CYCLES) ? MaxA : SPI_TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    localparam logic [CntW-1:0] PowerLast   = CntW'(POWER_UP_DELAY_CYCLES);
    localparam logic [CntW-1:0] GapLast     = CntW'(INTER_WRITE_GAP_CYCLES);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(SPI_TIMEOUT_CYCLES);
    localparam logic [3:0]      LastIdx     = 4'd9;

    typedef enum logic [3:0] {
        StPowerWait,
        StSend,
        StWaitDone,
        StGap,
        StReady,
        StVolSend,
        StVolWait,
        StVolGap,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [15:0]       data_q, data_d;
    logic              spi_valid_q;
    logic              vol_ready_q;
    logic              dp_en_q;
    logic              init_done_q;
    logic              error_q;

    function automatic logic [15:0] init_word(input logic [3:0] idx);
        case (idx)
            4'd0:    init_word = 16'h1E00;
            4'd1:    init_word = 16'h0C10;
            4'd2:    init_word = 16'h0017;
            4'd3:    init_word = 16'h0217;
            4'd4:    init_word = 16'h0812;
            4'd5:    init_word = 16'h0A00;
            4'd6:    init_word = 16'h0E0A;
            4'd7:    init_word = 16'h1000;
            4'd8:    init_word = 16'h1201;
            4'd9:    init_word = 16'h0C00;
            default: init_word = 16'h0000;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            StPowerWait: begin
                if (cnt_q == PowerLast) begin
                    state_d = StSend;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    data_d  = init_word(4'd0);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSend: begin
                if (i_spi_ready) begin
                    state_d = StWaitDone;
                    cnt_d   = '0;
                end
            end
            // A done sampled on the timeout cycle takes priority over the timeout.
            StWaitDone: begin
                if (i_spi_done) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StReady;
                    end else begin
                        state_d = StSend;
                        idx_d   = idx_q + 4'd1;
                        data_d  = init_word(idx_q + 4'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            // Both channels, no zero-cross detection.
            StReady: begin
                if (i_volume_valid) begin
                    state_d = StVolSend;
                    data_d  = {7'h02, 2'b10, i_volume_value};
                end
            end
            StVolSend: begin
                if (i_spi_ready) begin
                    state_d = StVolWait;
                    cnt_d   = '0;
                end
            end
            StVolWait: begin
                if (i_spi_done) begin
                    state_d = StVolGap;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StVolGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StError;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q     <= StPowerWait;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            spi_valid_q <= 1'b0;
            vol_ready_q <= 1'b0;
            dp_en_q     <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            spi_valid_q <= (state_d == StSend) || (state_d == StVolSend);
            vol_ready_q <= (state_d == StReady);
            dp_en_q     <= (state_d == StReady) || (state_d == StVolSend) ||
                           (state_d == StVolWait) || (state_d == StVolGap);
            init_done_q <= init_done_q || (state_d == StReady);
            error_q     <= (state_d == StError);
        end
    end

    assign o_spi_data        = data_q;
    assign o_spi_valid       = spi_valid_q;
    assign o_volume_ready    = vol_ready_q;
    assign o_datapath_enable = dp_en_q;
    assign o_init_done       = init_done_q;
    assign o_error           = error_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer: init table, stalls, volume writes, timeout, reset.
module tb_codec_config_sequencer;

    localparam int unsigned PowerDelay = 16;
    localparam int unsigned Gap        = 4;
    localparam int unsigned Timeout    = 64;

    localparam logic [15:0] InitWords [10] = '{
        16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0812,
        16'h0A00, 16'h0E0A, 16'h1000, 16'h1201, 16'h0C00
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] spi_data;
    logic        spi_valid;
    logic        spi_ready;
    logic        spi_done;
    logic        vol_valid;
    logic [6:0]  vol_value;
    logic        vol_ready;
    logic        dp_en;
    logic        init_done;
    logic        error;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    codec_config_sequencer #(
        .POWER_UP_DELAY_CYCLES  (PowerDelay),
        .INTER_WRITE_GAP_CYCLES (Gap),
        .SPI_TIMEOUT_CYCLES     (Timeout)
    ) dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .o_spi_data        (spi_data),
        .o_spi_valid       (spi_valid),
        .i_spi_ready       (spi_ready),
        .i_spi_done        (spi_done),
        .i_volume_valid    (vol_valid),
        .i_volume_value    (vol_value),
        .o_volume_ready    (vol_ready),
        .o_datapath_enable (dp_en),
        .o_init_done       (init_done),
        .o_error           (error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " spi_data"}, 32'(spi_data), 32'h0);
        check({tag, " spi_valid"}, 32'(spi_valid), 32'h0);
        check({tag, " volume_ready"}, 32'(vol_ready), 32'h0);
        check({tag, " datapath_enable"}, 32'(dp_en), 32'h0);
        check({tag, " init_done"}, 32'(init_done), 32'h0);
        check({tag, " error"}, 32'(error), 32'h0);
    endtask

    // Wait for valid, check the word, stall 'hold' extra cycles, then accept it.
    task automatic send_word(input logic [15:0] exp, input int hold, input bit chk_gap,
                             input string tag);
        int waited = 0;
        while (spi_valid !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        check({tag, " valid"}, 32'(spi_valid), 32'h1);
        if (chk_gap) check({tag, " gap cycles"}, 32'(waited), Gap + 1);
        check({tag, " word"}, 32'(spi_data), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            step();
            check($sformatf("%s stall%0d valid", tag, i), 32'(spi_valid), 32'h1);
            check($sformatf("%s stall%0d word", tag, i), 32'(spi_data), 32'(exp));
        end
        spi_ready = 1'b1;
        step();
        spi_ready = 1'b0;
        check({tag, " valid after accept"}, 32'(spi_valid), 32'h0);
    endtask

    task automatic pulse_done(input int delay);
        repeat (delay - 1) step();
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        spi_ready = 1'b0;
        spi_done  = 1'b0;
        vol_valid = 1'b0;
        vol_value = 7'h00;
        repeat (3) step();
        check_reset("reset");

        // Phase A: full init, ready preloaded so entry 0 hands off in its first valid cycle.
        spi_ready = 1'b1;
        rst_n     = 1'b1;
        cyc       = 0;
        while (spi_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("first valid cycle", 32'(cyc), PowerDelay + 1);
        check("entry0 word", 32'(spi_data), 32'h1E00);
        step();
        spi_ready = 1'b0;
        check("entry0 one-cycle handshake", 32'(spi_valid), 32'h0);
        check("init_done low during init", 32'(init_done), 32'h0);
        pulse_done(20);
        for (int i = 1; i < 10; i++) begin
            if (i == 3) begin
                vol_valid = 1'b1;
                vol_value = 7'h79;
            end
            send_word(InitWords[i], (i == 6) ? 6 : 0, 1'b1, $sformatf("init%0d", i));
            check($sformatf("init%0d volume_ready", i), 32'(vol_ready), 32'h0);
            check($sformatf("init%0d dp_en", i), 32'(dp_en), 32'h0);
            pulse_done(20);
        end
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("init_done after last done", 32'(cyc), Gap + 1);
        check("ready datapath_enable", 32'(dp_en), 32'h1);
        check("ready volume_ready", 32'(vol_ready), 32'h1);

        // Pending volume request is taken on the first READY cycle.
        step();
        vol_valid = 1'b0;
        check("vol1 ready drop", 32'(vol_ready), 32'h0);
        check("vol1 valid", 32'(spi_valid), 32'h1);
        check("vol1 word", 32'(spi_data), 32'h0579);
        check("vol1 dp_en send", 32'(dp_en), 32'h1);
        spi_ready = 1'b1;
        step();
        spi_ready = 1'b0;
        check("vol1 valid after accept", 32'(spi_valid), 32'h0);
        check("vol1 dp_en wait", 32'(dp_en), 32'h1);
        pulse_done(20);
        check("vol1 dp_en gap", 32'(dp_en), 32'h1);
        cyc = 0;
        while (vol_ready !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("vol1 ready return", 32'(cyc), Gap + 1);
        check("vol1 init_done kept", 32'(init_done), 32'h1);

        vol_valid = 1'b1;
        vol_value = 7'h3F;
        step();
        vol_valid = 1'b0;
        check("vol2 ready drop", 32'(vol_ready), 32'h0);
        check("vol2 word", 32'(spi_data), 32'h053F);
        spi_ready = 1'b1;
        step();
        spi_ready = 1'b0;
        pulse_done(3);
        cyc = 0;
        while (vol_ready !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("vol2 ready return", 32'(cyc), Gap + 1);

        // Phase B: reset during WAIT_DONE of entry 5.
        rst_n = 1'b0;
        step();
        check_reset("reset from ready");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_word(InitWords[i], 0, i != 0, $sformatf("run2 init%0d", i));
            if (i < 5) pulse_done(20);
        end
        repeat (5) step();
        rst_n = 1'b0;
        step();
        check_reset("reset mid-transfer");
        rst_n = 1'b1;
        cyc   = 0;
        while (spi_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("restart valid cycle", 32'(cyc), PowerDelay + 1);
        check("restart word", 32'(spi_data), 32'h1E00);

        // Phase C: done on the timeout cycle wins, then a real timeout on entry 2.
        send_word(InitWords[0], 0, 1'b0, "run3 init0");
        pulse_done(20);
        send_word(InitWords[1], 0, 1'b1, "run3 init1");
        repeat (Timeout) step();
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        check("done on timeout cycle no error", 32'(error), 32'h0);
        send_word(InitWords[2], 0, 1'b1, "run3 init2");
        cyc = 0;
        while (error !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        check("timeout cycles", 32'(cyc), Timeout + 1);
        check("error spi_valid", 32'(spi_valid), 32'h0);
        check("error dp_en", 32'(dp_en), 32'h0);
        check("error init_done kept", 32'(init_done), 32'h0);
        vol_valid = 1'b1;
        spi_ready = 1'b1;
        repeat (3) begin
            spi_done = 1'b1;
            step();
            spi_done = 1'b0;
            step();
        end
        repeat (20) step();
        check("error sticky", 32'(error), 32'h1);
        check("error spi_valid stays low", 32'(spi_valid), 32'h0);
        check("error volume_ready", 32'(vol_ready), 32'h0);
        check("error dp_en stays low", 32'(dp_en), 32'h0);
        vol_valid = 1'b0;
        spi_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
